wb_stage: RTL and testbench

- Writeback stage directly downstream of the execute stage.
- Merges two writeback streams onto the single register-file write port:
  - ALU/MULT/CSR results from execute (regfile_alu_*_fw);
  - load data from the LSU (regfile_lsu_*_wb).
- Load data cannot stall, so it always wins the port. A colliding ALU result is parked in a small ordered buffer and drained on free cycles.
- Drives wb_ready back to execute; optionally forwards buffered results to decode.

---
 rtl/wb_stage_pkg.sv | 12 +
 rtl/wb_buffer.sv | 87 ++++++++
 rtl/wb_stage.sv | 86 ++++++++
 tb/tb_wb_stage.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared types for the writeback stage: buffered ALU writeback entry and buffer sizing limit.
package wb_stage_pkg;

    localparam int WB_BUF_DEPTH_MAX = 8;

    typedef struct packed {
        logic        valid;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_buffer.sv
// Ordered circular buffer of parked ALU writebacks with kill-by-address and an optional
// youngest-match forwarding search (built only when WB_FWD_EN is defined).
module wb_buffer
    import wb_stage_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    input  logic             kill,
    input  logic [4:0]       kill_waddr,
    output wb_entry_t        head,
    output logic [CNT_W-1:0] count,
    input  logic [4:0]       fwd_raddr_a,
    input  logic [4:0]       fwd_raddr_b,
    output logic             fwd_hit_a,
    output logic             fwd_hit_b,
    output logic [31:0]      fwd_data_a,
    output logic [31:0]      fwd_data_b
);

    wb_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      head_ptr, tail_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Popped slots are cleared so that valid always implies the slot is occupied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem      <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++)
                    if (mem[i].waddr == kill_waddr) mem[i].valid <= 1'b0;
            end
            if (pop) begin
                mem[head_ptr].valid <= 1'b0;
                head_ptr            <= ptr_inc(head_ptr);
            end
            if (push) begin
                mem[tail_ptr] <= push_entry;
                tail_ptr      <= ptr_inc(tail_ptr);
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    assign head = mem[head_ptr];

`ifdef WB_FWD_EN
    // Walk oldest to youngest from the head so the last hit is the youngest.
    function automatic logic [32:0] lookup(input wb_entry_t [DEPTH-1:0] m,
                                           input logic [PTR_W-1:0] h,
                                           input logic [4:0] ra);
        logic [32:0]      r;
        logic [PTR_W-1:0] idx;
        r = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = PTR_W'((int'(h) + k) % DEPTH);
            if (m[idx].valid && m[idx].waddr == ra && ra != '0) r = {1'b1, m[idx].wdata};
        end
        return r;
    endfunction

    assign {fwd_hit_a, fwd_data_a} = lookup(mem, head_ptr, fwd_raddr_a);
    assign {fwd_hit_b, fwd_data_b} = lookup(mem, head_ptr, fwd_raddr_b);
`else
    logic fwd_unused;
    assign fwd_unused = ^{fwd_raddr_a, fwd_raddr_b};
    assign fwd_hit_a  = 1'b0;
    assign fwd_hit_b  = 1'b0;
    assign fwd_data_a = '0;
    assign fwd_data_b = '0;
`endif

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates load data and ALU results onto one regfile write port,
// parking colliding ALU results in wb_buffer. Decode forwarding exists only with WB_FWD_EN.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_we_i,
    input  logic [4:0]  alu_waddr_i,
    input  logic [31:0] alu_wdata_i,
    input  logic        lsu_we_i,
    input  logic [4:0]  lsu_waddr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        wb_ready_o,
    output logic        buf_empty_o,
    input  logic [4:0]  fwd_raddr_a_i,
    input  logic [4:0]  fwd_raddr_b_i,
    output logic        fwd_hit_a_o,
    output logic        fwd_hit_b_o,
    output logic [31:0] fwd_data_a_o,
    output logic [31:0] fwd_data_b_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0] count;
    wb_entry_t        head, push_entry;
    logic             alu_acc, bypass, push, pop;

    assign buf_empty_o = (count == '0);
    // A full buffer can still take a push when the head drains this cycle.
    assign wb_ready_o  = (count < CNT_W'(DEPTH)) || !lsu_we_i;

    assign alu_acc    = alu_we_i && (alu_waddr_i != '0) && wb_ready_o;
    assign bypass     = alu_acc && buf_empty_o && !lsu_we_i;
    assign push       = alu_acc && !bypass;
    assign pop        = !lsu_we_i && !buf_empty_o;
    assign push_entry = '{valid: 1'b1, waddr: alu_waddr_i, wdata: alu_wdata_i};

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (lsu_we_i) begin
            rf_we_o    = (lsu_waddr_i != '0);
            rf_waddr_o = lsu_waddr_i;
            rf_wdata_o = lsu_wdata_i;
        end else if (!buf_empty_o) begin
            rf_we_o    = head.valid;
            rf_waddr_o = head.waddr;
            rf_wdata_o = head.wdata;
        end else if (bypass) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = alu_waddr_i;
            rf_wdata_o = alu_wdata_i;
        end
    end

    wb_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .kill        (lsu_we_i),
        .kill_waddr  (lsu_waddr_i),
        .head        (head),
        .count       (count),
        .fwd_raddr_a (fwd_raddr_a_i),
        .fwd_raddr_b (fwd_raddr_b_i),
        .fwd_hit_a   (fwd_hit_a_o),
        .fwd_hit_b   (fwd_hit_b_o),
        .fwd_data_a  (fwd_data_a_o),
        .fwd_data_b  (fwd_data_b_o)
    );

    // Execute must hold its result while wb_ready_o is low.
    a_no_alu_when_stalled: assert property (@(posedge clk) disable iff (!rst_n)
        alu_we_i |-> wb_ready_o);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic against a queue model.
module tb_wb_stage;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we, lsu_we;
    logic [4:0]  alu_waddr, lsu_waddr, fwd_raddr_a, fwd_raddr_b;
    logic [31:0] alu_wdata, lsu_wdata;
    logic        rf_we_o, wb_ready_o, buf_empty_o, fwd_hit_a_o, fwd_hit_b_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o, fwd_data_a_o, fwd_data_b_o;

    int vectors = 0;
    int miscompares = 0;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we_i(alu_we), .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
        .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .wb_ready_o(wb_ready_o), .buf_empty_o(buf_empty_o),
        .fwd_raddr_a_i(fwd_raddr_a), .fwd_raddr_b_i(fwd_raddr_b),
        .fwd_hit_a_o(fwd_hit_a_o), .fwd_hit_b_o(fwd_hit_b_o),
        .fwd_data_a_o(fwd_data_a_o), .fwd_data_b_o(fwd_data_b_o)
    );

    always #5 clk = ~clk;

    // Register file as seen through the DUT write port.
    logic [31:0] obs_rf [32];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) obs_rf[i] <= '0;
        end else if (rf_we_o) begin
            obs_rf[rf_waddr_o] <= rf_wdata_o;
        end
    end

    typedef struct {
        bit        v;
        bit [4:0]  a;
        bit [31:0] d;
    } ent_t;

    task automatic drive(input bit lw, input bit [4:0] la, input bit [31:0] ld,
                         input bit aw, input bit [4:0] aa, input bit [31:0] ad);
        lsu_we = lw; lsu_waddr = la; lsu_wdata = ld;
        alu_we = aw; alu_waddr = aa; alu_wdata = ad;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0);
        fwd_raddr_a = 0; fwd_raddr_b = 0;
        rst_n = 1'b0;
        #3;
        vectors++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_rf: got %0h expected 0", {rf_we_o, rf_waddr_o, rf_wdata_o});
        end
        vectors++;
        if ({wb_ready_o, buf_empty_o, fwd_hit_a_o, fwd_hit_b_o} !== 4'b1100) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 1100",
                     {wb_ready_o, buf_empty_o, fwd_hit_a_o, fwd_hit_b_o});
        end
        vectors++;
        if ({fwd_data_a_o, fwd_data_b_o} !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_fwd_data: got %0h expected 0", {fwd_data_a_o, fwd_data_b_o});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        vectors++;
        if ({rf_we_o, wb_ready_o, buf_empty_o} !== 3'b011) begin
            miscompares++;
            $display("FAIL reset_idle: got %b expected 011", {rf_we_o, wb_ready_o, buf_empty_o});
        end
    endtask

    task automatic test_alu_bypass();
        drive(0, 0, 0, 1, 5, 32'hA5);
        #1;
        vectors++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'hA5}) begin
            miscompares++;
            $display("FAIL bypass_write: got %0h expected %0h", {rf_we_o, rf_waddr_o, rf_wdata_o},
                     {1'b1, 5'd5, 32'hA5});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({buf_empty_o, rf_we_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL bypass_empty: got %b expected 10", {buf_empty_o, rf_we_o});
        end
        @(negedge clk);
    endtask

    task automatic test_collision();
        drive(1, 7, 32'h11, 1, 8, 32'h22);
        #1;
        vectors++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'h11}) begin
            miscompares++;
            $display("FAIL collide_load: got %0h expected %0h", {rf_we_o, rf_waddr_o, rf_wdata_o},
                     {1'b1, 5'd7, 32'h11});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({buf_empty_o, rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 1'b1, 5'd8, 32'h22}) begin
            miscompares++;
            $display("FAIL collide_drain: got %0h expected %0h",
                     {buf_empty_o, rf_we_o, rf_waddr_o, rf_wdata_o}, {1'b0, 1'b1, 5'd8, 32'h22});
        end
        tick();
        vectors++;
        if ({buf_empty_o, rf_we_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL collide_empty: got %b expected 10", {buf_empty_o, rf_we_o});
        end
    endtask

    task automatic test_fill();
        bit [4:0] exp_a [3];
        exp_a[0] = 20; exp_a[1] = 21; exp_a[2] = 22;
        for (int c = 0; c < 2; c++) begin
            drive(1, 5'(10 + c), 32'h100 + c, 1, 5'(20 + c), 32'h200 + c);
            #1;
            vectors++;
            if (wb_ready_o !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready_c%0d: got %b expected 1", c, wb_ready_o);
            end
            tick();
        end
        drive(1, 12, 32'h102, 0, 0, 0);
        #1;
        vectors++;
        if ({wb_ready_o, rf_we_o, rf_waddr_o} !== {1'b0, 1'b1, 5'd12}) begin
            miscompares++;
            $display("FAIL fill_stall: got %0h expected %0h", {wb_ready_o, rf_we_o, rf_waddr_o},
                     {1'b0, 1'b1, 5'd12});
        end
        tick();
        drive(0, 0, 0, 1, 22, 32'h202);
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if ({wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o} !==
                {1'b1, 1'b1, exp_a[c], 32'h200 + 32'(c)}) begin
                miscompares++;
                $display("FAIL fill_drain_%0d: got %0h expected %0h", c,
                         {wb_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o},
                         {1'b1, 1'b1, exp_a[c], 32'h200 + 32'(c)});
            end
            tick();
            drive(0, 0, 0, 0, 0, 0);
        end
        #1;
        vectors++;
        if (buf_empty_o !== 1'b1) begin
            miscompares++;
            $display("FAIL fill_empty: got %b expected 1", buf_empty_o);
        end
        @(negedge clk);
    endtask

    task automatic test_kill();
        drive(1, 1, 32'h99, 1, 9, 32'h33);
        tick();
        drive(1, 9, 32'h44, 0, 0, 0);
        #1;
        vectors++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd9, 32'h44}) begin
            miscompares++;
            $display("FAIL kill_load: got %0h expected %0h", {rf_we_o, rf_waddr_o, rf_wdata_o},
                     {1'b1, 5'd9, 32'h44});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({buf_empty_o, rf_we_o} !== 2'b00) begin
            miscompares++;
            $display("FAIL kill_pop: got %b expected 00", {buf_empty_o, rf_we_o});
        end
        tick();
        vectors++;
        if ({buf_empty_o, obs_rf[9]} !== {1'b1, 32'h44}) begin
            miscompares++;
            $display("FAIL kill_final: got %0h expected %0h", {buf_empty_o, obs_rf[9]}, {1'b1, 32'h44});
        end
        // Same-cycle ALU result is younger than the load and must survive.
        drive(1, 9, 32'h55, 1, 9, 32'h66);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd9, 32'h66}) begin
            miscompares++;
            $display("FAIL kill_younger: got %0h expected %0h", {rf_we_o, rf_waddr_o, rf_wdata_o},
                     {1'b1, 5'd9, 32'h66});
        end
        tick();
    endtask

    task automatic test_x0();
        drive(0, 0, 0, 1, 0, 32'hDEAD);
        #1;
        vectors++;
        if ({rf_we_o, buf_empty_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL x0_alu: got %b expected 01", {rf_we_o, buf_empty_o});
        end
        tick();
        drive(1, 0, 32'hBEEF, 0, 0, 0);
        #1;
        vectors++;
        if (rf_we_o !== 1'b0) begin
            miscompares++;
            $display("FAIL x0_lsu: got %b expected 0", rf_we_o);
        end
        tick();
        drive(1, 4, 32'h4, 1, 0, 32'h1234);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({rf_we_o, buf_empty_o} !== 2'b01) begin
            miscompares++;
            $display("FAIL x0_no_enqueue: got %b expected 01", {rf_we_o, buf_empty_o});
        end
        @(negedge clk);
    endtask

    task automatic test_fwd_and_reset();
        drive(1, 1, 32'h1, 1, 3, 32'h1);
        tick();
        drive(1, 2, 32'h2, 1, 3, 32'h2);
        tick();
        drive(1, 4, 32'h4, 0, 0, 0);
        fwd_raddr_a = 3; fwd_raddr_b = 2;
        #1;
        vectors++;
        if ({fwd_hit_a_o, fwd_data_a_o} !== {FWD, FWD ? 32'h2 : 32'h0}) begin
            miscompares++;
            $display("FAIL fwd_a: got %0h expected %0h", {fwd_hit_a_o, fwd_data_a_o},
                     {FWD, FWD ? 32'h2 : 32'h0});
        end
        vectors++;
        if ({fwd_hit_b_o, fwd_data_b_o} !== 33'd0) begin
            miscompares++;
            $display("FAIL fwd_b_miss: got %0h expected 0", {fwd_hit_b_o, fwd_data_b_o});
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        vectors++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'h1}) begin
            miscompares++;
            $display("FAIL mid_drain: got %0h expected %0h", {rf_we_o, rf_waddr_o, rf_wdata_o},
                     {1'b1, 5'd3, 32'h1});
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({rf_we_o, rf_waddr_o, rf_wdata_o, wb_ready_o, buf_empty_o, fwd_hit_a_o, fwd_data_a_o} !==
            {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0}) begin
            miscompares++;
            $display("FAIL async_reset: got %0h expected %0h",
                     {rf_we_o, rf_waddr_o, rf_wdata_o, wb_ready_o, buf_empty_o, fwd_hit_a_o, fwd_data_a_o},
                     {1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0});
        end
        fwd_raddr_a = 0; fwd_raddr_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        ent_t        q[$];
        logic [31:0] arch_rf [32];
        bit          lw, aw, exp_ready, exp_we, acc, byp, was_empty, hit_a, hit_b;
        bit [4:0]    la, aa, exp_a;
        bit [31:0]   ld, ad, exp_d, dat_a, dat_b;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 32; i++) arch_rf[i] = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            lw = ($urandom_range(0, 9) < 4);
            la = 5'($urandom_range(0, 7));
            ld = $urandom;
            exp_ready = (q.size() < DEPTH) || !lw;
            aw = exp_ready && ($urandom_range(0, 3) != 0);
            aa = 5'($urandom_range(0, 7));
            ad = $urandom;
            fwd_raddr_a = 5'($urandom_range(0, 7));
            fwd_raddr_b = 5'($urandom_range(0, 7));
            drive(lw, la, ld, aw, aa, ad);
            was_empty = (q.size() == 0);
            acc = aw && (aa != 0) && exp_ready;
            byp = acc && was_empty && !lw;
            exp_we = 0; exp_a = 0; exp_d = 0;
            if (lw) begin
                exp_we = (la != 0); exp_a = la; exp_d = ld;
            end else if (!was_empty) begin
                exp_we = q[0].v; exp_a = q[0].a; exp_d = q[0].d;
            end else if (byp) begin
                exp_we = 1; exp_a = aa; exp_d = ad;
            end
            hit_a = 0; hit_b = 0; dat_a = 0; dat_b = 0;
            foreach (q[k]) begin
                if (FWD && q[k].v && q[k].a == fwd_raddr_a && fwd_raddr_a != 0) begin
                    hit_a = 1; dat_a = q[k].d;
                end
                if (FWD && q[k].v && q[k].a == fwd_raddr_b && fwd_raddr_b != 0) begin
                    hit_b = 1; dat_b = q[k].d;
                end
            end
            #1;
            vectors++;
            if ({wb_ready_o, buf_empty_o, rf_we_o} !== {exp_ready, was_empty, exp_we}) begin
                miscompares++;
                $display("FAIL rnd_ctrl cyc %0d: got %b expected %b", cyc,
                         {wb_ready_o, buf_empty_o, rf_we_o}, {exp_ready, was_empty, exp_we});
            end
            if (exp_we) begin
                vectors++;
                if ({rf_waddr_o, rf_wdata_o} !== {exp_a, exp_d}) begin
                    miscompares++;
                    $display("FAIL rnd_write cyc %0d: got %0h expected %0h", cyc,
                             {rf_waddr_o, rf_wdata_o}, {exp_a, exp_d});
                end
            end
            vectors++;
            if ({fwd_hit_a_o, fwd_data_a_o, fwd_hit_b_o, fwd_data_b_o} !== {hit_a, dat_a, hit_b, dat_b}) begin
                miscompares++;
                $display("FAIL rnd_fwd cyc %0d: got %0h expected %0h", cyc,
                         {fwd_hit_a_o, fwd_data_a_o, fwd_hit_b_o, fwd_data_b_o}, {hit_a, dat_a, hit_b, dat_b});
            end
            @(posedge clk);
            // Program order: the load precedes any ALU result accepted in the same cycle.
            if (lw && la != 0) arch_rf[la] = ld;
            if (acc) arch_rf[aa] = ad;
            if (lw) begin
                foreach (q[k]) if (q[k].a == la) q[k].v = 0;
            end else if (!was_empty) begin
                void'(q.pop_front());
            end
            if (acc && !byp) q.push_back('{v: 1'b1, a: aa, d: ad});
            @(negedge clk);
        end
        drive(0, 0, 0, 0, 0, 0);
        fwd_raddr_a = 0; fwd_raddr_b = 0;
        repeat (DEPTH + 1) tick();
        vectors++;
        if (buf_empty_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rnd_drain_timeout: buf_empty got %b expected 1", buf_empty_o);
        end
        for (int r = 1; r < 32; r++) begin
            vectors++;
            if (obs_rf[r] !== arch_rf[r]) begin
                miscompares++;
                $display("FAIL rnd_regfile x%0d: got %0h expected %0h", r, obs_rf[r], arch_rf[r]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_bypass();
        test_collision();
        test_fill();
        test_kill();
        test_x0();
        test_fwd_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
